// File: rtl/user_word_tx.sv
// user_word_tx: frames a run of upstream user words behind a header word
// that carries the word count, so the remote receiver can size its capture.
// Sits between the mode/cfg decode logic and the link framer.
//
// Optional feature: define USER_WORD_TX_CSUM_EN to append a trailer word
// holding the XOR of all user words sent in the frame. Without it the frame
// ends on the last user word (or on the header when the count is zero).
//
// State table:
//   state   | meaning
//   IDLE    | waiting for i_start; counts above MAX_WORDS raise o_err
//   HDR     | presenting the header word {8'hA5, 0..., count}
//   WORDS   | pass-through of upstream user words, remaining counts down
//   TRL     | presenting the checksum trailer (USER_WORD_TX_CSUM_EN only)
//   DONE    | one-cycle o_done pulse, then back to IDLE
module user_word_tx #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [3:0]        i_user_word_count,
    input  logic              i_word_valid,
    input  logic [DATA_W-1:0] i_word_data,
    output logic              o_word_ready,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_last,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_WORDS = 3'd2;
`ifdef USER_WORD_TX_CSUM_EN
    localparam logic [2:0] S_TRL   = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    // Count input is 4 bits wide, so the legal limit is compared at that width.
    localparam logic [3:0] MAX_CNT = 4'(MAX_WORDS);

    // State after the final user word (or after the header when count is 0).
`ifdef USER_WORD_TX_CSUM_EN
    localparam logic [2:0] S_AFTER_WORDS = S_TRL;
`else
    localparam logic [2:0] S_AFTER_WORDS = S_DONE;
`endif

    logic [2:0]        state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [3:0]        remaining_q, remaining_d;
    logic              err_q, err_d;
`ifdef USER_WORD_TX_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif
    logic [DATA_W-1:0] hdr_word;
    logic              word_hs;

    // Upstream word moves to the link only when both sides agree in WORDS.
    assign word_hs = (state_q == S_WORDS) && i_word_valid && i_tx_ready;

    // Header layout: marker byte on top, count in the low nibble, zeros between.
    always_comb begin
        hdr_word                  = '0;
        hdr_word[DATA_W-1 -: 8]   = 8'hA5;
        hdr_word[3:0]             = count_q;
    end

    // Next-state, count/remaining bookkeeping and error pulse generation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
`ifdef USER_WORD_TX_CSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_user_word_count > MAX_CNT) begin
                        // Rejected requests leave every register untouched.
                        err_d = 1'b1;
                    end else begin
                        count_d     = i_user_word_count;
                        remaining_d = i_user_word_count;
`ifdef USER_WORD_TX_CSUM_EN
                        csum_d      = '0;
`endif
                        state_d     = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (i_tx_ready) begin
                    state_d = (count_q != 4'd0) ? S_WORDS : S_AFTER_WORDS;
                end
            end
            S_WORDS: begin
                if (word_hs) begin
                    remaining_d = remaining_q - 4'd1;
`ifdef USER_WORD_TX_CSUM_EN
                    csum_d      = csum_q ^ i_word_data;
`endif
                    if (remaining_q == 4'd1) begin
                        state_d = S_AFTER_WORDS;
                    end
                end
            end
`ifdef USER_WORD_TX_CSUM_EN
            S_TRL: begin
                if (i_tx_ready) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            count_q     <= 4'd0;
            remaining_q <= 4'd0;
            err_q       <= 1'b0;
`ifdef USER_WORD_TX_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
`ifdef USER_WORD_TX_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Output stream mux: header/trailer come from registers, so they hold
    // naturally under back-pressure; user words pass straight through.
    always_comb begin
        o_tx_valid   = 1'b0;
        o_tx_data    = '0;
        o_tx_last    = 1'b0;
        o_word_ready = 1'b0;
        case (state_q)
            S_HDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = hdr_word;
`ifdef USER_WORD_TX_CSUM_EN
                o_tx_last  = 1'b0;
`else
                o_tx_last  = (count_q == 4'd0);
`endif
            end
            S_WORDS: begin
                o_tx_valid   = i_word_valid;
                o_tx_data    = i_word_data;
                o_word_ready = i_tx_ready;
`ifdef USER_WORD_TX_CSUM_EN
                o_tx_last    = 1'b0;
`else
                o_tx_last    = (remaining_q == 4'd1);
`endif
            end
`ifdef USER_WORD_TX_CSUM_EN
            S_TRL: begin
                o_tx_valid = 1'b1;
                o_tx_data  = csum_q;
                o_tx_last  = 1'b1;
            end
`endif
            default: begin
                o_tx_valid   = 1'b0;
                o_tx_data    = '0;
                o_tx_last    = 1'b0;
                o_word_ready = 1'b0;
            end
        endcase
    end

    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DONE);
    assign o_err  = err_q;

endmodule

// File: tb/tb_user_word_tx.sv
// Bench for user_word_tx: a frame-level model builds the expected output
// stream (header, user words, optional XOR trailer) as a queue, and every
// downstream handshake is compared against it.
module tb_user_word_tx;

    localparam int DW   = 32;
    localparam int MAXW = 8;
`ifdef USER_WORD_TX_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [3:0]    i_user_word_count;
    logic          i_word_valid;
    logic [DW-1:0] i_word_data;
    logic          o_word_ready;
    logic          o_tx_valid;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_last;
    logic          i_tx_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    user_word_tx #(.DATA_W(DW), .MAX_WORDS(MAXW)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (i_start),
        .i_user_word_count (i_user_word_count),
        .i_word_valid      (i_word_valid),
        .i_word_data       (i_word_data),
        .o_word_ready      (o_word_ready),
        .o_tx_valid        (o_tx_valid),
        .o_tx_data         (o_tx_data),
        .o_tx_last         (o_tx_last),
        .i_tx_ready        (i_tx_ready),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err)
    );

    function automatic logic [DW-1:0] header_of(input int cnt);
        logic [DW-1:0] h;
        h = '0;
        h[DW-1 -: 8] = 8'hA5;
        h[3:0] = 4'(cnt);
        return h;
    endfunction

    // Runs one accepted frame. ready_mode: 0 always ready, 1 toggling, 2 random.
    task automatic run_frame(input logic [DW-1:0] words[$], input int ready_mode,
                             input bit gaps, input bit start_noise, input string tag);
        logic [DW-1:0] src[$];
        logic [DW-1:0] exp_d[$];
        bit            exp_l[$];
        logic [DW-1:0] csum;
        logic [DW-1:0] st_d;
        logic          st_l;
        bit            pend, stall;
        int cnt, cyc, hs_cnt, last_hs, done_cyc, hdr_cyc;
        src = words;
        cnt = words.size();
        exp_d.push_back(header_of(cnt));
        exp_l.push_back(CS == 0 && cnt == 0);
        csum = '0;
        for (int i = 0; i < cnt; i++) begin
            exp_d.push_back(words[i]);
            exp_l.push_back(CS == 0 && i == cnt - 1);
            csum = csum ^ words[i];
        end
        if (CS != 0) begin
            exp_d.push_back(csum);
            exp_l.push_back(1'b1);
        end
        hs_cnt = 0; last_hs = -1; done_cyc = -1; hdr_cyc = -1;
        pend = 0; stall = 0; st_d = '0; st_l = 0;

        @(negedge clk);
        i_start = 1'b1;
        i_user_word_count = 4'(cnt);
        i_tx_ready = 1'b1;
        i_word_valid = 1'b0;
        i_word_data = '0;
        #1;
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_busy: got %b want 0", tag, o_busy);
        end
        cyc = 0;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            i_start = start_noise && (exp_d.size() > 0) && ($urandom_range(3) == 0);
            i_user_word_count = 4'($urandom_range(15));
            case (ready_mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = (cyc % 2) == 1;
                default: i_tx_ready = 1'($urandom_range(1));
            endcase
            if (src.size() == 0)  i_word_valid = 1'b0;
            else if (pend)        i_word_valid = 1'b1;
            else if (gaps)        i_word_valid = ($urandom_range(3) != 0);
            else                  i_word_valid = 1'b1;
            i_word_data = (src.size() > 0) ? src[0] : DW'($urandom);
            #1;
            n_tests++;
            if (o_err !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_err cyc %0d: got busy=%b err=%b want 1 0",
                         tag, cyc, o_busy, o_err);
            end
            if (stall) begin
                n_tests++;
                if (o_tx_valid !== 1'b1 || o_tx_data !== st_d || o_tx_last !== st_l) begin
                    n_fail++;
                    $display("FAIL %s hold cyc %0d: got v=%b d=%h l=%b want 1 %h %b",
                             tag, cyc, o_tx_valid, o_tx_data, o_tx_last, st_d, st_l);
                end
            end
            if (o_word_ready === 1'b1) begin
                n_tests++;
                if (i_tx_ready !== 1'b1 ||
                    (i_word_valid && (o_tx_valid !== 1'b1 || o_tx_data !== i_word_data))) begin
                    n_fail++;
                    $display("FAIL %s passthru cyc %0d: got v=%b d=%h want 1 %h ready=%b",
                             tag, cyc, o_tx_valid, o_tx_data, i_word_data, i_tx_ready);
                end
            end
            if (o_tx_valid === 1'b1 && i_tx_ready) begin
                n_tests++;
                if (exp_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_word cyc %0d: got %h want none", tag, cyc, o_tx_data);
                end else begin
                    if (o_tx_data !== exp_d[0] || o_tx_last !== exp_l[0]) begin
                        n_fail++;
                        $display("FAIL %s word%0d: got %h last %b want %h last %b",
                                 tag, hs_cnt, o_tx_data, o_tx_last, exp_d[0], exp_l[0]);
                    end
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                end
                if (hdr_cyc < 0) hdr_cyc = cyc;
                hs_cnt++;
                last_hs = cyc;
            end
            if (o_done === 1'b1) begin
                done_cyc = cyc;
                n_tests++;
                if (exp_d.size() != 0 || last_hs != cyc - 1) begin
                    n_fail++;
                    $display("FAIL %s done_pos: got left=%0d last_hs=%0d want 0 %0d",
                             tag, exp_d.size(), last_hs, cyc - 1);
                end
            end
            stall = o_tx_valid && !i_tx_ready;
            st_d  = o_tx_data;
            st_l  = o_tx_last;
            if (o_word_ready && i_word_valid) begin
                void'(src.pop_front());
                pend = 0;
            end else begin
                pend = i_word_valid;
            end
        end
        n_tests++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL %s timeout: got no o_done want o_done", tag);
        end
        n_tests++;
        if (hs_cnt != cnt + 1 + CS) begin
            n_fail++;
            $display("FAIL %s hs_count: got %0d want %0d", tag, hs_cnt, cnt + 1 + CS);
        end
        if (ready_mode == 0 && !gaps) begin
            n_tests++;
            if (hdr_cyc != 1 || done_cyc != cnt + 2 + CS) begin
                n_fail++;
                $display("FAIL %s timing: got hdr@%0d done@%0d want hdr@1 done@%0d",
                         tag, hdr_cyc, done_cyc, cnt + 2 + CS);
            end
        end
        @(negedge clk);
        i_start = 1'b0;
        i_word_valid = 1'b0;
        i_tx_ready = 1'b1;
        #1;
        n_tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_idle: got busy=%b done=%b valid=%b want 0 0 0",
                     tag, o_busy, o_done, o_tx_valid);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_tests++;
        if (o_tx_valid !== 1'b0 || o_tx_data !== '0 || o_tx_last !== 1'b0 ||
            o_word_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s outputs: got v=%b d=%h l=%b wr=%b busy=%b done=%b err=%b want all 0",
                     tag, o_tx_valid, o_tx_data, o_tx_last, o_word_ready, o_busy, o_done, o_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        i_tx_ready = 1'b1;
        i_word_valid = 1'b1;
        i_word_data = 32'hDEADBEEF;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        i_word_valid = 1'b0;
    endtask

    task automatic test_count3();
        logic [DW-1:0] w[$];
        w = {32'h11, 32'h22, 32'h33};
        run_frame(w, 0, 0, 0, "count3");
    endtask

    task automatic test_count0();
        logic [DW-1:0] w[$];
        w = {};
        run_frame(w, 0, 0, 0, "count0");
    endtask

    task automatic test_err();
        int c;
        for (int k = 0; k < 4; k++) begin
            c = (k == 0) ? 9 : int'($urandom_range(15, 9));
            @(negedge clk);
            i_start = 1'b1;
            i_user_word_count = 4'(c);
            i_tx_ready = 1'b1;
            #1;
            @(negedge clk);
            i_start = 1'b0;
            #1;
            n_tests++;
            if (o_err !== 1'b1 || o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pulse cnt %0d: got err=%b busy=%b valid=%b want 1 0 0",
                         c, o_err, o_busy, o_tx_valid);
            end
            @(negedge clk);
            #1;
            n_tests++;
            if (o_err !== 1'b0 || o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL err_clear cnt %0d: got err=%b busy=%b valid=%b want 0 0 0",
                         c, o_err, o_busy, o_tx_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[$];
        w = {};
        for (int i = 0; i < 8; i++) w.push_back(DW'($urandom));
        run_frame(w, 1, 1, 0, "bp_count8");
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w[$];
        @(negedge clk);
        i_start = 1'b1;
        i_user_word_count = 4'd5;
        i_tx_ready = 1'b1;
        i_word_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_word_valid = 1'b1;
            i_word_data = DW'($urandom);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_word_valid = 1'b1;
        i_tx_ready = 1'b1;
        i_word_data = 32'hCAFEF00D;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        i_word_valid = 1'b0;
        w = {DW'($urandom)};
        run_frame(w, 0, 0, 0, "after_reset");
    endtask

    task automatic test_start_during();
        logic [DW-1:0] w[$];
        w = {};
        for (int i = 0; i < 6; i++) w.push_back(DW'($urandom));
        run_frame(w, 0, 0, 1, "start_noise");
    endtask

    task automatic test_random();
        logic [DW-1:0] w[$];
        int c;
        for (int f = 0; f < 12; f++) begin
            c = int'($urandom_range(MAXW));
            w = {};
            for (int i = 0; i < c; i++) w.push_back(DW'($urandom));
            run_frame(w, 2, 1, f[0], $sformatf("rand%0d", f));
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_user_word_count = 4'd0;
        i_word_valid = 1'b0;
        i_word_data = '0;
        i_tx_ready = 1'b0;
        test_reset();
        test_count3();
        test_count0();
        test_err();
        test_backpressure();
        test_reset_mid();
        test_start_during();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/user_word_tx.md
# user_word_tx

- Transmit-side counterpart of the user-word-count decoder.
- Takes the decoded `i_user_word_count` (0..8) with a start pulse, emits one header word carrying the count, then forwards exactly that many user words from an upstream source onto a valid/ready output stream.
- Sits between the mode/cfg decode logic and the link framer; the remote receiver uses the header to size its capture.

## Interface
- `DATA_W`, default 32: width of header, user and trailer words; minimum 16.
- `MAX_WORDS`, default 8: largest legal count; larger counts are rejected.
- `i_clk` in 1: single clock; all logic rising-edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_start` in 1: one-cycle request to send a frame; sampled only in IDLE.
- `i_user_word_count` in 4: number of user words for this frame; sampled with `i_start`.
- `i_word_valid` in 1: upstream user word available.
- `i_word_data` in DATA_W: upstream user word.
- `o_word_ready` out 1: upstream word consumed this cycle when high with `i_word_valid`.
- `o_tx_valid` out 1: output word valid.
- `o_tx_data` out DATA_W: output word.
- `o_tx_last` out 1: final word of frame.
- `i_tx_ready` in 1: downstream accepts the output word.
- `o_busy` out 1: high in any state other than IDLE.
- `o_done` out 1: one-cycle pulse after the last word handshakes.
- `o_err` out 1: one-cycle pulse when a start carries count > MAX_WORDS.

## Operation
- **States:** IDLE, HDR, WORDS, TRL (trailer; only with the config macro), DONE.
- **IDLE**
  - On `i_start` with count <= MAX_WORDS: latch count into `remaining`, go to HDR.
  - On `i_start` with count > MAX_WORDS: pulse `o_err` next cycle, stay in IDLE, latch nothing.
  - `i_start` in any other state is ignored; no error is raised.
- **HDR**
  - `o_tx_valid`=1.
  - `o_tx_data`: [DATA_W-1:DATA_W-8]=8'hA5, [3:0]=latched count, all other bits 0.
  - `o_tx_last`=1 only if count==0 and the trailer is compiled out.
  - On handshake: go to WORDS if count>0; otherwise go to TRL or DONE.
- **WORDS** (pure pass-through, no buffering)
  - `o_tx_valid`=`i_word_valid`; `o_tx_data`=`i_word_data`; `o_word_ready`=`i_tx_ready`.
  - `remaining` decrements on each handshake.
  - `o_tx_last`=1 when `remaining`==1 and the trailer is compiled out.
  - On the handshake with `remaining`==1: go to TRL or DONE.
- **DONE:** `o_done`=1 for one cycle, then IDLE.
- **Outside WORDS:** `o_word_ready`=0.
- **Holding rule:** output data and last stay stable while valid is high and ready is low, in HDR and TRL. In WORDS the upstream is responsible for this.
- **Reset at any time:** next cycle state=IDLE, `remaining`=0, checksum=0. Any partial frame is abandoned; no `o_done`, no `o_err`.
- **Reset values of outputs:** `o_tx_valid`, `o_tx_last`, `o_word_ready`, `o_busy`, `o_done`, `o_err` are 0; `o_tx_data` is 0.

## Timing
- `i_start` at cycle N: header valid at cycle N+1.
- With `i_tx_ready` held high, the header handshakes at N+1.
- `o_word_ready`, `o_tx_valid` and `o_tx_data` in WORDS are combinational from inputs; zero added latency.
- Full-throughput frame with count K and no trailer: header at N+1, words at N+2..N+K+1, `o_done` at N+K+2, new `i_start` accepted at N+K+3.
- `o_err` asserts at N+1 for a rejected start.
- Back-pressure: any cycle with valid&&!ready stalls the FSM with no loss or duplication.

## Configuration
- **`USER_WORD_TX_CSUM_EN` defined:**
  - A TRL state follows the last user word, or follows HDR when count==0.
  - TRL emits one trailer word: XOR of all user words sent in this frame (0 when count==0).
  - The trailer carries `o_tx_last`=1; neither HDR nor user words assert last.
  - The checksum register clears on start acceptance.
- **Not defined:** TRL and the checksum register are absent; last behaves as stated in Operation.

## Test plan
- **Count 3, ready always high, words 0x11, 0x22, 0x33:**
  - Stream is 0xA5000003, 0x11, 0x22, 0x33; last on 0x33; `o_done` at N+5.
  - With CSUM_EN: a trailer word 0x00000000 follows with last.
- **Count 0:** single header 0xA5000000 with last; `o_done` two cycles after start. With CSUM_EN: header, then trailer 0 with last.
- **Count 9 (MAX_WORDS=8):** `o_err` one cycle at N+1, `o_busy` stays 0, no `o_tx_valid`.
- **Count 8, `i_tx_ready` toggling 1,0,1,0 and upstream valid gaps:** exactly 9 handshakes; data unchanged across every stall; one `o_done`.
- **Reset mid-frame:** assert `i_rst` after 2 of 5 words. Next cycle all outputs are 0 and the FSM is in IDLE; a following start with count 1 sends a clean header plus one word.
- **`i_start` pulsed during WORDS:** ignored; the current frame completes unchanged and no second header is emitted.
